ex_div_seq: RTL
===============

// Module: ex_div_seq
// PURPOSE
//  Multi-cycle divide sequencer for the EX stage. It runs MIPS DIV/DIVU as a radix-2 restoring
//  divider, producing one quotient bit per cycle, and raises a stall request for the CTRL stall bus.
//  EX drives start/operands from the id_to_ex register and consumes {rem,quo} into HI/LO when ready.
//  It is the sole owner of the shared divide datapath; EX holds start high until ready.
// PARAMETERS
//  WIDTH   32   operand width; also the iteration count
// PORTS
//  clk           in   1          pipeline clock; single clock domain
//  rst           in   1          synchronous, active-high reset
//  start         in   1          divide request from EX; held high by EX until ready
//  signed_div    in   1          1 = DIV (two's complement), 0 = DIVU
//  annul         in   1          flush: abandon the current operation
//  opdata1       in   WIDTH      dividend
//  opdata2       in   WIDTH      divisor
//  result        out  2*WIDTH    {remainder[63:32], quotient[31:0]}, registered
//  ready         out  1          result valid for the current request
//  stallreq_div  out  1          to CTRL: stall IF/ID/EX while the divide is incomplete
// BEHAVIOUR
//  Reset: state=IDLE, result=0, ready=0, cnt=0, work register=0.
//  rst and annul override every other input, in any state.
//  States: IDLE, DIVZERO, BUSY, DONE. Encoding is free.
//  IDLE:
//   - start&&!annul && opdata2==0 -> DIVZERO.
//   - start&&!annul -> BUSY: latch |opdata1|, |opdata2| (magnitude only if signed_div),
//     latch sign bits, cnt<=0.
//   - Operands are sampled only here; input changes during BUSY are ignored.
//  BUSY, each cycle:
//   - diff = work_hi - divisor, computed WIDTH+1 bits wide.
//   - diff>=0: work <= {diff, work_lo, 1}. Otherwise shift left and insert 0.
//   - cnt++. At cnt==WIDTH-1 -> DONE and load result:
//     - quotient negated when signed_div && sign(a)!=sign(b);
//     - remainder takes the sign of the dividend (negated if signed_div && a<0).
//  DIVZERO: result <= 0 (quo=0, rem=0; defined value for the architecturally undefined case);
//   -> DONE next cycle.
//  DONE:
//   - ready=1.
//   - start==0 -> IDLE with ready<=0.
//   - start stays high -> remain in DONE; no new divide begins until start drops for >=1 cycle.
//  annul in BUSY/DIVZERO/DONE -> IDLE next cycle; ready<=0; result keeps its previous value.
//  stallreq_div = (IDLE && start && !annul) || BUSY || DIVZERO. It is combinational; in DONE it is 0.
//  result holds its value until the next DONE entry, so HI/LO writeback may sample late.
//  Latency, with start first seen in IDLE at cycle T:
//   - normal: BUSY T+1..T+32, ready=1 at T+33, stallreq high T..T+32;
//   - divide by zero: ready at T+2.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quo=0x80000000, rem=0 (wraps, no trap).
//  Mid-operation reset: next cycle IDLE with all outputs 0.
// TESTING
//  1. DIVU 100/7, start held -> stallreq T..T+32; ready at T+33; result={32'd2, 32'd14}.
//  2. DIV -7/2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF. DIV 7/-2 -> quo=0xFFFFFFFD, rem=0x00000001.
//  3. DIV 5/0 -> DIVZERO at T+1; ready=1 at T+2; result=0; stallreq 0 at T+2.
//  4. DIVU 0xFFFFFFFF/1, annul pulsed at T+10 -> IDLE at T+11; stallreq=0; ready never asserts;
//     result unchanged. New DIVU 9/3 then completes with quo=3, rem=0.
//  5. DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0; DIVU 0xFFFFFFFF/0xFFFFFFFF -> quo=1, rem=0.
//  6. rst high at T+15 of a divide -> T+16 ready=0, result=0, stallreq=0 (start low).
//     Start held through DONE -> no restart until start drops.

Source files
------------

// File: rtl/ex_div_seq_if.sv
// Handshake bundle between the EX stage (master) and the divide sequencer (slave).
// Carries the request, operands, the registered {rem,quo} result and the CTRL stall request.
interface ex_div_seq_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               signed_div;
   logic               annul;
   logic [WIDTH-1:0]   opdata1;
   logic [WIDTH-1:0]   opdata2;
   logic [2*WIDTH-1:0] result;
   logic               ready;
   logic               stallreq_div;

   modport master (
      output start, signed_div, annul, opdata1, opdata2,
      input  result, ready, stallreq_div
   );

   modport slave (
      input  start, signed_div, annul, opdata1, opdata2,
      output result, ready, stallreq_div
   );
endinterface

// File: rtl/ex_div_seq.sv
// Radix-2 restoring divide sequencer for MIPS DIV/DIVU: one quotient bit per cycle,
// sign-magnitude around an unsigned core, stall request to CTRL while incomplete.
module ex_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   ex_div_seq_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_BUSY,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_work;
   logic [WIDTH-1:0]     r_divisor;
   logic                 r_neg_quo;
   logic                 r_neg_rem;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_ready;

   logic                 w_req;
   logic                 w_last;
   logic                 w_stall;
   logic [WIDTH+1:0]     w_trial;
   logic [2*WIDTH-1:0]   w_work_nx;

   function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   assign w_req  = bus.start && !bus.annul;
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // Shifted partial remainder is below 2*divisor, so a non-negative trial always fits in WIDTH bits.
   always_comb begin
      w_trial = {1'b0, r_work[2*WIDTH-1:WIDTH-1]} - {2'b00, r_divisor};
      if (!w_trial[WIDTH+1])
         w_work_nx = {w_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
      else
         w_work_nx = {r_work[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      w_state_nx = r_state;
      w_stall    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_stall    = 1'b1;
               w_state_nx = (bus.opdata2 == '0) ? S_DIVZERO : S_BUSY;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (bus.annul)
               w_state_nx = S_IDLE;
            else if (w_last)
               w_state_nx = S_DONE;
         end
         S_DIVZERO: begin
            w_stall    = 1'b1;
            w_state_nx = bus.annul ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (bus.annul || !bus.start)
               w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_neg_quo <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b0;
               if (w_req && bus.opdata2 != '0) begin
                  r_work    <= {{WIDTH{1'b0}},
                                f_cneg(bus.opdata1, bus.signed_div && bus.opdata1[WIDTH-1])};
                  r_divisor <= f_cneg(bus.opdata2, bus.signed_div && bus.opdata2[WIDTH-1]);
                  r_neg_quo <= bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                  r_neg_rem <= bus.signed_div && bus.opdata1[WIDTH-1];
                  r_cnt     <= '0;
               end
            end
            S_BUSY: begin
               if (bus.annul) begin
                  r_ready <= 1'b0;
               end else begin
                  r_work <= w_work_nx;
                  r_cnt  <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_result <= {f_cneg(w_work_nx[2*WIDTH-1:WIDTH], r_neg_rem),
                                  f_cneg(w_work_nx[WIDTH-1:0], r_neg_quo)};
                     r_ready  <= 1'b1;
                  end
               end
            end
            S_DIVZERO: begin
               if (bus.annul) begin
                  r_ready <= 1'b0;
               end else begin
                  r_result <= '0;
                  r_ready  <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.annul || !bus.start)
                  r_ready <= 1'b0;
            end
            default: r_ready <= 1'b0;
         endcase
      end
   end

   assign bus.result       = r_result;
   assign bus.ready        = r_ready;
   assign bus.stallreq_div = w_stall;
endmodule
